// File: rtl/mont_ctrl.sv
// Montgomery multiplication sequencer for the carry-save mpadder.
// Computes C = A*B*2^-N mod M by driving the adder through N bit-serial
// accumulate/halve steps, five carry-resolve phases and up to MAX_SUB
// subtract rounds of M. The reduced value is captured and `done` pulses.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; operands latched on acceptance
// S_CLEAR   | adder carry-save registers cleared via add_resetn
// S_ADDA    | accumulate B[i] ? A : 0
// S_ADDM    | add q*M (q = current sum LSB) and halve
// S_RESOLVE | carry-resolve phases 0..4
// S_SUB     | subtract-M round, phases 0..4; exits on adder carry or limit
// S_CAPTURE | adder copies its last non-negative value to its result reg
// S_DONE    | result registered; done pulses on the following cycle
module mont_ctrl #(
    parameter int N       = 512,
    parameter int MAX_SUB = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic [N-1:0] op_m,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] result,
    output logic         add_resetn,
    output logic [N+1:0] add_in,
    output logic         add_subtract,
    output logic         add_shift,
    output logic         add_enableC,
    output logic [3:0]   add_phase,
    input  logic         add_cZero,
    input  logic         add_carry,
    input  logic [N+1:0] add_result
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (MAX_SUB > 1) ? $clog2(MAX_SUB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ADDA, S_ADDM, S_RESOLVE, S_SUB, S_CAPTURE, S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  bit_idx;
    logic [2:0]     phase;
    logic [RW-1:0]  round;
    logic [N-1:0]   a_q, b_q, m_q;
    logic           accept, last_bit, last_phase, last_round;

    // The adder's two guard bits never reach the reduced result.
    logic unused_add_hi;
    assign unused_add_hi = ^add_result[N+1:N];

    // Start is held off while done is high so a request in the done cycle is dropped.
    assign accept     = (state == S_IDLE) && start && !done;
    assign last_bit   = (bit_idx == IW'(N - 1));
    assign last_phase = (phase == 3'd4);
    assign last_round = (round == RW'(MAX_SUB - 1));

    // State register, operand latches, counters and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_idx <= '0;
            phase   <= '0;
            round   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        m_q     <= op_m;
                        bit_idx <= '0;
                        phase   <= '0;
                        round   <= '0;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_ADDM: begin
                    if (last_bit) begin
                        bit_idx <= '0;
                        phase   <= '0;
                    end else begin
                        bit_idx <= bit_idx + IW'(1);
                    end
                end
                S_RESOLVE: begin
                    if (last_phase) begin
                        phase <= '0;
                        round <= '0;
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                S_SUB: begin
                    if (last_phase) begin
                        phase <= '0;
                        if (!add_carry) begin
                            if (last_round) error <= 1'b1;
                            else            round <= round + RW'(1);
                        end
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
                S_DONE: begin
                    result <= add_result[N-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and adder control outputs; add_cZero feeds add_in in ADDM directly.
    always_comb begin
        state_nxt    = state;
        add_resetn   = 1'b1;
        add_in       = '0;
        add_subtract = 1'b0;
        add_shift    = 1'b0;
        add_enableC  = 1'b0;
        add_phase    = 4'd0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                add_resetn = 1'b0;
                state_nxt  = S_ADDA;
            end
            S_ADDA: begin
                add_in      = b_q[bit_idx] ? {2'b00, a_q} : '0;
                add_enableC = 1'b1;
                state_nxt   = S_ADDM;
            end
            S_ADDM: begin
                add_in    = add_cZero ? {2'b00, m_q} : '0;
                add_shift = 1'b1;
                state_nxt = last_bit ? S_RESOLVE : S_ADDA;
            end
            S_RESOLVE: begin
                add_phase = {1'b0, phase};
                if (last_phase) state_nxt = S_SUB;
            end
            S_SUB: begin
                add_subtract = 1'b1;
                add_in       = {2'b11, ~m_q};
                add_phase    = {1'b0, phase};
                if (last_phase && (add_carry || last_round)) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                add_subtract = 1'b1;
                state_nxt    = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mont_ctrl.sv
// Bench for mont_ctrl at N=8 with a behavioural adder stub (binary sum,
// carry resolution is a no-op, subtract rounds reduce by M while the sum
// stays non-negative).
module tb_mont_ctrl;

    localparam int N = 8;
    localparam int W = N + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] op_a = '0, op_b = '0, op_m = '0;
    logic         busy, done, error;
    logic [N-1:0] result;
    logic         add_resetn;
    logic [W-1:0] add_in;
    logic         add_subtract, add_shift, add_enableC;
    logic [3:0]   add_phase;
    logic         add_cZero, add_carry;
    logic [W-1:0] add_result;

    int checks = 0;
    int passed = 0;
    bit force_nc = 1'b0;

    mont_ctrl #(.N(N), .MAX_SUB(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .op_a(op_a), .op_b(op_b), .op_m(op_m),
        .busy(busy), .done(done), .error(error), .result(result),
        .add_resetn(add_resetn), .add_in(add_in),
        .add_subtract(add_subtract), .add_shift(add_shift),
        .add_enableC(add_enableC), .add_phase(add_phase),
        .add_cZero(add_cZero), .add_carry(add_carry), .add_result(add_result)
    );

    always #5 clk = ~clk;

    // Adder stub
    logic [W-1:0] s_reg = '0;
    logic [W-1:0] t_reg = '0;
    logic [W:0]   diff;
    logic [W-1:0] after_sub;
    logic         carry_raw;

    assign diff       = {1'b0, s_reg} + {1'b0, add_in} + {{W{1'b0}}, 1'b1};
    assign after_sub  = diff[W] ? diff[W-1:0] : s_reg;
    assign carry_raw  = add_subtract && (add_phase == 4'd4) &&
                        (after_sub < {2'b00, ~add_in[N-1:0]});
    assign add_carry  = carry_raw && !force_nc;
    assign add_cZero  = s_reg[0];
    assign add_result = t_reg;

    always @(posedge clk) begin
        if (!add_resetn)      s_reg <= '0;
        else if (add_enableC) s_reg <= s_reg + add_in;
        else if (add_shift)   s_reg <= (s_reg + add_in) >> 1;
        else if (add_subtract && add_phase == 4'd4 && diff[W]) s_reg <= diff[W-1:0];
        if (add_subtract && add_phase == 4'd0 && add_in == '0) t_reg <= s_reg;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Golden: (a*b mod m) halved modulo m, N times.
    function automatic int unsigned golden(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
        int unsigned r;
        r = (a * b) % m;
        for (int k = 0; k < N; k++) begin
            if (r[0]) r = r + m;
            r = r >> 1;
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input int unsigned a, input int unsigned b,
                          input int unsigned m, input int unsigned exp_res,
                          input int exp_lat, input bit exp_err,
                          input int inject, input bit start_at_done);
        int lat;
        int extra;
        bit busy_bad;
        op_a = N'(a); op_b = N'(b); op_m = N'(m);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_clear"}, add_resetn, 0);
        chk({tag, "_err_clr"}, error, 0);
        lat = 0;
        busy_bad = 1'b0;
        while (!done && lat < 120) begin
            if (!busy) busy_bad = 1'b1;
            if (lat == inject) begin
                op_a = 8'd5; op_b = 8'd7; op_m = 8'd13;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_busy_held"}, busy_bad, 0);
        if (start_at_done) begin
            op_a = 8'd1; op_b = 8'd1; op_m = 8'd3;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        if (inject >= 0) begin
            extra = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (done) extra++;
            end
            chk({tag, "_no_2nd_done"}, extra, 0);
            chk({tag, "_result_kept"}, result, exp_res);
        end
    endtask

    initial begin
        int unsigned ra, rb, rm;
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_add_resetn", add_resetn, 1);
        chk("rst_add_in", add_in, 0);
        chk("rst_add_ctl", {add_subtract, add_shift, add_enableC, add_phase}, 0);
        reset = 1'b0;
        tick();

        // 35 * 2^-8 mod 13 = 1; start held in the done cycle must be dropped
        run_op("smoke", 5, 7, 13, 1, 29, 0, -1, 1);
        run_op("zero_a", 0, 200, 251, 0, 29, 0, -1, 0);
        run_op("one_one", 1, 1, 13, 3, 29, 0, -1, 0);
        run_op("max_res", 12, 12, 13, 3, 29, 0, -1, 0);
        run_op("full_w", 254, 254, 255, 1, 29, 0, -1, 0);
        run_op("mid", 100, 3, 101, 28, 29, 0, -1, 0);

        run_op("start_busy", 100, 3, 101, 28, 29, 0, 10, 0);

        force_nc = 1'b1;
        run_op("sub_limit", 5, 7, 13, 1, 44, 1, -1, 0);
        force_nc = 1'b0;
        run_op("err_clear", 12, 12, 13, 3, 29, 0, -1, 0);

        // Reset during RESOLVE phase 2
        op_a = 8'd100; op_b = 8'd3; op_m = 8'd101;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        chk("mid_resolve_phase", add_phase, 2);
        chk("mid_resolve_sub", add_subtract, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_phase", add_phase, 0);
        chk("midrst_add_in", add_in, 0);
        run_op("after_rst", 5, 7, 13, 1, 29, 0, -1, 0);

        for (int v = 0; v < 6; v++) begin
            rm = 2 * $urandom_range(1, 127) + 1;
            ra = $urandom_range(0, rm - 1);
            rb = $urandom_range(0, rm - 1);
            run_op("rand", ra, rb, rm, golden(ra, rb, rm), 29, 0, -1, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
